// File: rtl/lzc_pkg.sv
// Shared definitions for the leading-zero/one stream counter.
package lzc_pkg;

  localparam logic LZC_MODE_ZERO = 1'b0;
  localparam logic LZC_MODE_ONE  = 1'b1;

  typedef enum logic {
    SEARCH = 1'b0,
    FOUND  = 1'b1
  } lzc_state_e;

  // Width needed to hold a count of 0..data_w inclusive.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/lzc_segment.sv
// Combinational MSB-first priority encoder for one segment of the scanned word.
// o_cnt is the number of leading zeros (0..SEG_W); o_all flags an all-zero segment.
module lzc_segment
  import lzc_pkg::*;
#(
  parameter  int SEG_W  = 8,
  localparam int SEG_CW = cnt_width(SEG_W)
) (
  input  logic [SEG_W-1:0]  i_data,
  output logic [SEG_CW-1:0] o_cnt,
  output logic              o_all
);

  logic w_found;

  // First set bit from the top decides the count; none set means the segment is all-run.
  always_comb begin
    o_cnt   = SEG_CW'(SEG_W);
    w_found = 1'b0;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      if (!w_found && i_data[SEG_W-1-i]) begin
        w_found = 1'b1;
        o_cnt   = SEG_CW'(i);
      end
    end
    o_all = !w_found;
  end

endmodule

// File: rtl/lzc_stream.sv
// Two-stage pipelined leading-zero/one counter with valid/ready handshake and a
// saturating per-packet leading-run accumulator.
// Optional feature: define LZC_STREAM_NORM_EN to add the oNorm normalised-word output.
module lzc_stream
  import lzc_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NSEG   = 4,
  parameter  int TOT_W  = 16,
  localparam int CNT_W  = cnt_width(DATA_W)
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iData,
  input  logic              iMode,
  input  logic              iLast,
  output logic              oValid,
  input  logic              iReady,
  output logic [CNT_W-1:0]  oCount,
  output logic              oAllRun,
  output logic [TOT_W-1:0]  oTotal,
  output logic              oLast
`ifdef LZC_STREAM_NORM_EN
  ,
  output logic [DATA_W-1:0] oNorm
`endif
);

  localparam int SEG_W  = DATA_W / NSEG;
  localparam int SEG_CW = cnt_width(SEG_W);
  localparam int SUM_W  = TOT_W + CNT_W;

  logic                         w_en;
  logic [DATA_W-1:0]            w_scan;
  logic [NSEG-1:0][SEG_CW-1:0]  w_seg_cnt;
  logic [NSEG-1:0]              w_seg_all;

  logic                         r_s1_valid;
  logic                         r_s1_last;
  logic [NSEG-1:0][SEG_CW-1:0]  r_s1_cnt;
  logic [NSEG-1:0]              r_s1_all;
`ifdef LZC_STREAM_NORM_EN
  logic [DATA_W-1:0]            r_s1_data;
`endif

  logic [CNT_W-1:0]             w_cnt;
  logic                         w_allrun;
  logic [SUM_W-1:0]             w_sum;
  logic [TOT_W-1:0]             w_sat;
  logic [TOT_W-1:0]             w_total;
  logic                         w_beat;

  lzc_state_e                   r_state;
  lzc_state_e                   w_state_nxt;
  logic [TOT_W-1:0]             r_acc;
  logic [TOT_W-1:0]             w_acc_nxt;

  // Whole pipeline advances together whenever the output register can be refilled.
  assign w_en   = !oValid || iReady;
  assign oReady = w_en;

  // Leading ones are counted as leading zeros of the inverted word.
  assign w_scan = (iMode == LZC_MODE_ONE) ? ~iData : iData;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    lzc_segment #(
      .SEG_W(SEG_W)
    ) u_seg (
      .i_data(w_scan[g*SEG_W +: SEG_W]),
      .o_cnt (w_seg_cnt[g]),
      .o_all (w_seg_all[g])
    );
  end

  // Stage 1: capture per-segment results and beat sideband.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_cnt   <= '0;
      r_s1_all   <= '0;
`ifdef LZC_STREAM_NORM_EN
      r_s1_data  <= '0;
`endif
    end else if (w_en) begin
      r_s1_valid <= iValid;
      r_s1_last  <= iLast;
      r_s1_cnt   <= w_seg_cnt;
      r_s1_all   <= w_seg_all;
`ifdef LZC_STREAM_NORM_EN
      r_s1_data  <= iData;
`endif
    end
  end

  // Merge segments from the top down; a segment contributes only while every segment above it is all-run.
  always_comb begin
    w_cnt    = '0;
    w_allrun = 1'b1;
    for (int unsigned i = 0; i < NSEG; i++) begin
      if (w_allrun) begin
        w_cnt = w_cnt + CNT_W'(r_s1_cnt[NSEG-1-i]);
      end
      w_allrun = w_allrun && r_s1_all[NSEG-1-i];
    end
  end

  // Saturating add of this beat's count onto the packet accumulator.
  always_comb begin
    w_sum = SUM_W'(r_acc) + SUM_W'(w_cnt);
    w_sat = (w_sum[SUM_W-1:TOT_W] != '0) ? '1 : w_sum[TOT_W-1:0];
  end

  assign w_beat = w_en && r_s1_valid;

  // Packet FSM: accumulate until the first word that is not entirely leading-run, clear after a last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_total     = r_acc;
    if (r_state == SEARCH) begin
      w_total = w_sat;
    end
    if (w_beat) begin
      if (r_s1_last) begin
        w_state_nxt = SEARCH;
        w_acc_nxt   = '0;
      end else begin
        w_acc_nxt = w_total;
        if ((r_state == SEARCH) && !w_allrun) begin
          w_state_nxt = FOUND;
        end
      end
    end
  end

  // Packet FSM state and accumulator registers.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state <= SEARCH;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // Stage 2: output registers, held while downstream stalls.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oValid  <= 1'b0;
      oCount  <= '0;
      oAllRun <= 1'b0;
      oTotal  <= '0;
      oLast   <= 1'b0;
`ifdef LZC_STREAM_NORM_EN
      oNorm   <= '0;
`endif
    end else if (w_en) begin
      oValid <= r_s1_valid;
      if (r_s1_valid) begin
        oCount  <= w_cnt;
        oAllRun <= w_allrun;
        oTotal  <= w_total;
        oLast   <= r_s1_last;
`ifdef LZC_STREAM_NORM_EN
        oNorm   <= r_s1_data << w_cnt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lzc_stream.sv
// Directed bench for lzc_stream: default instance plus a TOT_W=6 instance sharing the same stimulus.
module tb_lzc_stream;

  logic        clk;
  logic        iReset;
  logic        iValid;
  logic [31:0] iData;
  logic        iMode;
  logic        iLast;
  logic        iReady;

  logic        oReady, oValid, oAllRun, oLast;
  logic [5:0]  oCount;
  logic [15:0] oTotal;

  logic        o6Ready, o6Valid, o6AllRun, o6Last;
  logic [5:0]  o6Count;
  logic [5:0]  o6Total;

`ifdef LZC_STREAM_NORM_EN
  logic [31:0] oNorm;
  logic [31:0] o6Norm;
`endif

  int vectors = 0;
  int miscompares = 0;

  lzc_stream #(
    .DATA_W(32),
    .NSEG  (4),
    .TOT_W (16)
  ) u_dut (
    .iClk   (clk),
    .iReset (iReset),
    .iValid (iValid),
    .oReady (oReady),
    .iData  (iData),
    .iMode  (iMode),
    .iLast  (iLast),
    .oValid (oValid),
    .iReady (iReady),
    .oCount (oCount),
    .oAllRun(oAllRun),
    .oTotal (oTotal),
    .oLast  (oLast)
`ifdef LZC_STREAM_NORM_EN
    ,
    .oNorm  (oNorm)
`endif
  );

  lzc_stream #(
    .DATA_W(32),
    .NSEG  (4),
    .TOT_W (6)
  ) u_dut6 (
    .iClk   (clk),
    .iReset (iReset),
    .iValid (iValid),
    .oReady (o6Ready),
    .iData  (iData),
    .iMode  (iMode),
    .iLast  (iLast),
    .oValid (o6Valid),
    .iReady (iReady),
    .oCount (o6Count),
    .oAllRun(o6AllRun),
    .oTotal (o6Total),
    .oLast  (o6Last)
`ifdef LZC_STREAM_NORM_EN
    ,
    .oNorm  (o6Norm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic m, input logic l);
    iValid = v;
    iData  = d;
    iMode  = m;
    iLast  = l;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic out_chk(input string tag, input logic [5:0] cnt, input logic all,
                         input logic [15:0] tot, input logic last);
    chk({tag, ".valid"}, 64'(oValid), 64'(1'b1));
    chk({tag, ".cnt"},   64'(oCount), 64'(cnt));
    chk({tag, ".all"},   64'(oAllRun), 64'(all));
    chk({tag, ".tot"},   64'(oTotal), 64'(tot));
    chk({tag, ".last"},  64'(oLast), 64'(last));
  endtask

  int          tx;
  int          rx;
  int          cyc;
  logic        stalled_prev;
  logic [5:0]  snap_cnt;
  logic [15:0] snap_tot;
  logic        snap_all;

  initial begin
    iReset = 1'b1;
    iReady = 1'b1;
    idle();
    tick();
    tick();

    // Reset state
    chk("rst.valid", 64'(oValid), 64'(1'b0));
    chk("rst.cnt",   64'(oCount), 64'(6'd0));
    chk("rst.all",   64'(oAllRun), 64'(1'b0));
    chk("rst.tot",   64'(oTotal), 64'(16'd0));
    chk("rst.last",  64'(oLast), 64'(1'b0));
    chk("rst.ready", 64'(oReady), 64'(1'b1));
    chk("rst.tot6",  64'(o6Total), 64'(6'd0));
`ifdef LZC_STREAM_NORM_EN
    chk("rst.norm",  64'(oNorm), 64'(32'h0));
`endif
    iReset = 1'b0;
    tick();

    // Single beat, 2-cycle latency
    drive(1'b1, 32'h0000_8000, 1'b0, 1'b1);
    tick();
    idle();
    chk("lat1.valid", 64'(oValid), 64'(1'b0));
    tick();
    out_chk("t8000", 6'd16, 1'b0, 16'd16, 1'b1);
`ifdef LZC_STREAM_NORM_EN
    chk("t8000.norm", 64'(oNorm), 64'(32'h8000_0000));
`endif

    // Three-beat packet: all-run words accumulate, third stops the run
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    out_chk("p1b0", 6'd32, 1'b1, 16'd32, 1'b0);
    chk("p1b0.tot6", 64'(o6Total), 64'(6'd32));
    drive(1'b1, 32'h00F0_0000, 1'b0, 1'b1);
    tick();
    out_chk("p1b1", 6'd32, 1'b1, 16'd64, 1'b0);
    chk("p1b1.tot6", 64'(o6Total), 64'(6'd63));
    idle();
    tick();
    out_chk("p1b2", 6'd8, 1'b0, 16'd72, 1'b1);
    chk("p1b2.tot6", 64'(o6Total), 64'(6'd63));

    // Leading ones, new packet restarts from zero
    drive(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    out_chk("m1", 6'd28, 1'b0, 16'd28, 1'b1);
`ifdef LZC_STREAM_NORM_EN
    chk("m1.norm", 64'(oNorm), 64'(32'h0));
`endif

    // Zero word in mode 1 moves to FOUND; later all-run words leave total frozen
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    out_chk("f0", 6'd0, 1'b0, 16'd0, 1'b0);
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b1);
    tick();
    out_chk("f1", 6'd32, 1'b1, 16'd0, 1'b0);
    idle();
    tick();
    out_chk("f2", 6'd0, 1'b0, 16'd0, 1'b1);

    // Mixed modes inside one packet
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h0FFF_FFFF, 1'b0, 1'b1);
    tick();
    out_chk("mx0", 6'd32, 1'b1, 16'd32, 1'b0);
    idle();
    tick();
    out_chk("mx1", 6'd4, 1'b0, 16'd36, 1'b1);

    // Low byte pattern
    drive(1'b1, 32'h0000_00A5, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    out_chk("a5", 6'd24, 1'b0, 16'd24, 1'b1);
`ifdef LZC_STREAM_NORM_EN
    chk("a5.norm", 64'(oNorm), 64'(32'hA500_0000));
`endif

    // Saturation on the 6-bit accumulator
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    chk("sat0.tot",  64'(oTotal), 64'(16'd32));
    chk("sat0.tot6", 64'(o6Total), 64'(6'd32));
    drive(1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    chk("sat1.tot",  64'(oTotal), 64'(16'd64));
    chk("sat1.tot6", 64'(o6Total), 64'(6'd63));
    idle();
    tick();
    chk("sat2.tot",  64'(oTotal), 64'(16'd96));
    chk("sat2.tot6", 64'(o6Total), 64'(6'd63));
    chk("sat2.last6", 64'(o6Last), 64'(1'b1));
    tick();
    chk("drain.valid", 64'(oValid), 64'(1'b0));

    // Eight-beat stream with a 3-cycle downstream stall
    tx = 0;
    rx = 0;
    cyc = 0;
    stalled_prev = 1'b0;
    snap_cnt = '0;
    snap_tot = '0;
    snap_all = 1'b0;
    while (rx < 8 && cyc < 60) begin
      iReady = !(cyc >= 4 && cyc < 7);
      if (tx < 8) drive(1'b1, 32'h8000_0000 >> tx, 1'b0, 1'b1);
      else idle();
      #1;
      if (oValid && !iReady) begin
        chk("stall.ready", 64'(oReady), 64'(1'b0));
        if (stalled_prev) begin
          chk("stall.cnt", 64'(oCount), 64'(snap_cnt));
          chk("stall.tot", 64'(oTotal), 64'(snap_tot));
          chk("stall.all", 64'(oAllRun), 64'(snap_all));
        end else begin
          snap_cnt = oCount;
          snap_tot = oTotal;
          snap_all = oAllRun;
        end
      end
      stalled_prev = oValid && !iReady;
      if (oValid && iReady) begin
        chk("order.cnt", 64'(oCount), 64'(rx));
        chk("order.tot", 64'(oTotal), 64'(rx));
        rx++;
      end
      if (iValid && oReady) tx++;
      cyc++;
      tick();
    end
    chk("stream.rx", 64'(rx), 64'(8));
    chk("stream.tx", 64'(tx), 64'(8));
    iReady = 1'b1;
    idle();
    tick();
    tick();
    chk("stream.drain", 64'(oValid), 64'(1'b0));

    // Reset with two beats of an open packet in flight
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    chk("mid.pre", 64'(oValid), 64'(1'b1));
    idle();
    iReset = 1'b1;
    #1;
    chk("mid.valid", 64'(oValid), 64'(1'b0));
    chk("mid.tot",   64'(oTotal), 64'(16'd0));
    tick();
    iReset = 1'b0;
    drive(1'b1, 32'h0000_0001, 1'b0, 1'b1);
    tick();
    idle();
    chk("mid.bubble", 64'(oValid), 64'(1'b0));
    tick();
    out_chk("mid.post", 6'd31, 1'b0, 16'd31, 1'b1);
    chk("mid.post.tot6", 64'(o6Total), 64'(6'd31));
    tick();
    chk("mid.noghost", 64'(oValid), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
